mem_agent_rd_engine: RTL and testbench

- Parametrised AXI4 read-traffic engine for the memory agent.
- Issues INCR bursts over a configurable address window and caps in-flight bursts at a configurable limit.
- Forwards read data into a downstream FIFO using the team's wrreq/full write-interface convention.
- Keeps debug counters for bursts, beats, error responses and elapsed cycles.

---
 rtl/mem_agent_rd_engine_if.sv | 33 +++
 rtl/mem_agent_rd_engine.sv | 180 ++++++++++++++++++
 tb/tb_mem_agent_rd_engine.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_agent_rd_engine_if.sv
// AXI4 read-address/read-data channels plus the downstream FIFO write port
// used by the memory agent read engine.
interface mem_agent_rd_engine_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [ID_WIDTH-1:0]   arid;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  fifo_wrreq;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic                  fifo_full;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready, fifo_wrreq, fifo_wdata,
    input  arready, rvalid, rdata, rresp, rlast, fifo_full
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready, fifo_wrreq, fifo_wdata,
    output arready, rvalid, rdata, rresp, rlast, fifo_full
  );
endinterface

// File: rtl/mem_agent_rd_engine.sv
// AXI4 read-traffic engine: issues INCR bursts over an address window with a cap
// on in-flight bursts, forwards read beats into a FIFO and keeps debug counters.
module mem_agent_rd_engine #(
  parameter int                    DATA_WIDTH      = 128,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    ID_WIDTH        = 4,
  parameter int                    BURST_BEATS     = 16,
  parameter int                    OUTSTANDING_MAX = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE       = 'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_HIGH       = 'h8000_0000,
  parameter int                    CNT_BITS        = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [CNT_BITS-1:0]          num_bursts,
  mem_agent_rd_engine_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic [8:0]                   outstanding,
  output logic                         err_sticky,
  output logic [CNT_BITS-1:0]          bursts_issued,
  output logic [CNT_BITS-1:0]          beats_rcvd,
  output logic [CNT_BITS-1:0]          err_beats,
  output logic [CNT_BITS-1:0]          run_cycles
);

  localparam int                  BURST_BYTES = BURST_BEATS * DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] BURST_STEP  = (ADDR_WIDTH+1)'(BURST_BYTES);
  localparam logic [8:0]          OUT_MAX     = 9'(OUTSTANDING_MAX);
  localparam logic [CNT_BITS-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_reg, state_next;
  logic                  arvalid_reg, arvalid_next;
  logic                  stop_seen_reg, stop_seen_next;
  logic [8:0]            outstanding_reg, outstanding_next;
  logic [ADDR_WIDTH-1:0] araddr_reg;
  logic [ID_WIDTH-1:0]   arid_reg;
  logic [CNT_BITS-1:0]   num_reg;
  logic [CNT_BITS-1:0]   bursts_reg, bursts_next;
  logic [CNT_BITS-1:0]   beats_reg, err_beats_reg, run_cycles_reg;
  logic                  err_sticky_reg;
  logic                  clear;

  logic                  ar_hs, ar_pending, r_hs, r_err, rlast_dec, limit_hit, busy_int;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [ADDR_WIDTH-1:0] araddr_step;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  assign bus.arvalid    = arvalid_reg;
  assign bus.araddr     = araddr_reg;
  assign bus.arid       = arid_reg;
  assign bus.arlen      = 8'(BURST_BEATS - 1);
  assign bus.arsize     = 3'($clog2(DATA_WIDTH / 8));
  assign bus.arburst    = 2'b01;
  assign bus.rready     = !bus.fifo_full;
  assign bus.fifo_wrreq = bus.rvalid && bus.rready;
  assign bus.fifo_wdata = bus.rdata;

  assign ar_hs      = arvalid_reg && bus.arready;
  assign ar_pending = arvalid_reg && !bus.arready;
  assign r_hs       = bus.rvalid && bus.rready;
  assign r_err      = (bus.rresp != 2'b00);
  // A stray rlast with nothing in flight must not underflow the count.
  assign rlast_dec  = r_hs && bus.rlast && (outstanding_reg != 9'd0);
  assign bursts_next = sat_inc(bursts_reg, ar_hs);
  assign limit_hit  = ar_hs && (num_reg != '0) && (bursts_next == num_reg);
  assign busy_int   = (state_reg == S_RUN) || (state_reg == S_DRAIN);

  assign addr_sum    = {1'b0, araddr_reg} + BURST_STEP;
  assign araddr_step = (addr_sum >= {1'b0, ADDR_HIGH}) ? ADDR_BASE : addr_sum[ADDR_WIDTH-1:0];

  always_comb begin
    outstanding_next = outstanding_reg;
    if (ar_hs && !rlast_dec)
      outstanding_next = outstanding_reg + 9'd1;
    else if (!ar_hs && rlast_dec)
      outstanding_next = outstanding_reg - 9'd1;
  end

  always_comb begin
    state_next     = state_reg;
    arvalid_next   = arvalid_reg;
    stop_seen_next = stop_seen_reg;
    clear          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next     = S_RUN;
          arvalid_next   = 1'b1;
          stop_seen_next = 1'b0;
          clear          = 1'b1;
        end
      end
      S_RUN: begin
        if (stop)
          stop_seen_next = 1'b1;
        // A stop arriving while an AR is pending waits for that handshake.
        if (limit_hit || ((stop || stop_seen_reg) && !ar_pending)) begin
          state_next   = S_DRAIN;
          arvalid_next = 1'b0;
        end else begin
          arvalid_next = ar_pending || (outstanding_next < OUT_MAX);
        end
      end
      S_DRAIN: begin
        arvalid_next = 1'b0;
        if (outstanding_reg == 9'd0)
          state_next = S_DONE;
      end
      S_DONE: begin
        arvalid_next = 1'b0;
        state_next   = S_IDLE;
      end
      default: begin
        arvalid_next = 1'b0;
        state_next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      arvalid_reg     <= 1'b0;
      stop_seen_reg   <= 1'b0;
      outstanding_reg <= 9'd0;
      araddr_reg      <= ADDR_BASE;
      arid_reg        <= '0;
      num_reg         <= '0;
      bursts_reg      <= '0;
      beats_reg       <= '0;
      err_beats_reg   <= '0;
      run_cycles_reg  <= '0;
      err_sticky_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      arvalid_reg     <= arvalid_next;
      stop_seen_reg   <= stop_seen_next;
      outstanding_reg <= outstanding_next;
      if (clear) begin
        araddr_reg     <= ADDR_BASE;
        arid_reg       <= '0;
        num_reg        <= num_bursts;
        bursts_reg     <= '0;
        beats_reg      <= '0;
        err_beats_reg  <= '0;
        run_cycles_reg <= '0;
        err_sticky_reg <= 1'b0;
      end else begin
        if (ar_hs) begin
          araddr_reg <= araddr_step;
          arid_reg   <= arid_reg + 1'b1;
        end
        bursts_reg     <= bursts_next;
        beats_reg      <= sat_inc(beats_reg, r_hs);
        err_beats_reg  <= sat_inc(err_beats_reg, r_hs && r_err);
        run_cycles_reg <= sat_inc(run_cycles_reg, busy_int);
        if (r_hs && r_err)
          err_sticky_reg <= 1'b1;
      end
    end
  end

  assign busy          = busy_int;
  assign done          = (state_reg == S_DONE);
  assign outstanding   = outstanding_reg;
  assign err_sticky    = err_sticky_reg;
  assign bursts_issued = bursts_reg;
  assign beats_rcvd    = beats_reg;
  assign err_beats     = err_beats_reg;
  assign run_cycles    = run_cycles_reg;

endmodule

// File: tb/tb_mem_agent_rd_engine.sv
// Directed bench for mem_agent_rd_engine: default-window instance plus a
// small-window instance for address wrap.
module tb_mem_agent_rd_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, stop;
  logic [31:0] num_bursts;
  logic        busy, done, err_sticky;
  logic [8:0]  outstanding;
  logic [31:0] bursts_issued, beats_rcvd, err_beats, run_cycles;

  logic        start_w, stop_w;
  logic [31:0] num_w;
  logic        busy_w, done_w, err_sticky_w;
  logic [8:0]  outstanding_w;
  logic [31:0] bursts_issued_w, beats_rcvd_w, err_beats_w, run_cycles_w;

  mem_agent_rd_engine_if bus ();
  mem_agent_rd_engine_if bus_w ();

  mem_agent_rd_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .num_bursts(num_bursts),
    .bus(bus), .busy(busy), .done(done), .outstanding(outstanding),
    .err_sticky(err_sticky), .bursts_issued(bursts_issued), .beats_rcvd(beats_rcvd),
    .err_beats(err_beats), .run_cycles(run_cycles)
  );

  mem_agent_rd_engine #(.ADDR_HIGH(32'h4000_0300)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .stop(stop_w), .num_bursts(num_w),
    .bus(bus_w), .busy(busy_w), .done(done_w), .outstanding(outstanding_w),
    .err_sticky(err_sticky_w), .bursts_issued(bursts_issued_w), .beats_rcvd(beats_rcvd_w),
    .err_beats(err_beats_w), .run_cycles(run_cycles_w)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] ar_addr_log[$];
  logic [3:0]  ar_id_log[$];
  logic [31:0] arw_log[$];

  always @(posedge clk) begin
    if (bus.arvalid && bus.arready) begin
      ar_addr_log.push_back(bus.araddr);
      ar_id_log.push_back(bus.arid);
      $display("AR  addr=%08h id=%0d", bus.araddr, bus.arid);
    end
    if (bus_w.arvalid && bus_w.arready) begin
      arw_log.push_back(bus_w.araddr);
      $display("ARW addr=%08h", bus_w.araddr);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit last, input logic [15:0] errmask);
    for (int i = 0; i < n; i++) begin
      bus.rvalid = 1'b1;
      bus.rlast  = last && (i == n - 1);
      bus.rdata  = 128'(i);
      bus.rresp  = errmask[i] ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  // Called at the negedge right after the last rlast handshake in DRAIN.
  task automatic expect_done(input string tag);
    check({tag, "_pre_done"}, done, 1'b0);
    check({tag, "_pre_busy"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_done_busy"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_drop"}, done, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    start = 0; stop = 0; num_bursts = 0;
    start_w = 0; stop_w = 0; num_w = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 0; bus.rlast = 0; bus.fifo_full = 0;
    bus_w.arready = 1; bus_w.rvalid = 0; bus_w.rdata = '0; bus_w.rresp = 0; bus_w.rlast = 0; bus_w.fifo_full = 0;
    repeat (2) @(negedge clk);

    // Reset state and constant AR fields
    check("rst_arvalid", bus.arvalid, 1'b0);
    check("rst_araddr", bus.araddr, 32'h4000_0000);
    check("rst_arid", bus.arid, 4'd0);
    check("rst_outstanding", outstanding, 9'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bursts", bursts_issued, 32'd0);
    check("rst_err_sticky", err_sticky, 1'b0);
    check("rst_rready", bus.rready, 1'b1);
    check("arlen", bus.arlen, 8'd15);
    check("arsize", bus.arsize, 3'd4);
    check("arburst", bus.arburst, 2'b01);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: four bursts, full data return
    bus.arready = 1'b1; num_bursts = 4;
    base = ar_addr_log.size();
    pulse_start();
    check("t1_arvalid_first", bus.arvalid, 1'b1);
    check("t1_busy", busy, 1'b1);
    repeat (6) @(negedge clk);
    check("t1_ar_count", ar_addr_log.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), ar_addr_log[base + i], 32'h4000_0000 + 32'(i * 256));
      check($sformatf("t1_id%0d", i), ar_id_log[base + i], 4'(i));
    end
    check("t1_bursts", bursts_issued, 32'd4);
    check("t1_outstanding", outstanding, 9'd4);
    check("t1_arvalid_off", bus.arvalid, 1'b0);
    check("t1_run_cycles", run_cycles, 32'd6);
    bus.rvalid = 1'b1; bus.rlast = 1'b0; bus.rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5;
    #1;
    check("t1_wrreq", bus.fifo_wrreq, 1'b1);
    check("t1_wdata", bus.fifo_wdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5);
    @(negedge clk);
    send_beats(15, 1, 16'h0);
    for (int b = 0; b < 3; b++) send_beats(16, 1, 16'h0);
    check("t1_beats", beats_rcvd, 32'd64);
    check("t1_outstanding_end", outstanding, 9'd0);
    check("t1_err_beats", err_beats, 32'd0);
    expect_done("t1");

    // T2: continuous mode saturates at the outstanding limit
    bus.arready = 1'b1; num_bursts = 0;
    base = ar_addr_log.size();
    pulse_start();
    check("t2_run_cycles_clr", run_cycles, 32'd0);
    repeat (25) @(negedge clk);
    check("t2_ar_count", ar_addr_log.size() - base, 16);
    check("t2_outstanding", outstanding, 9'd16);
    check("t2_arvalid_low", bus.arvalid, 1'b0);
    check("t2_bursts", bursts_issued, 32'd16);
    send_beats(16, 1, 16'h0);
    repeat (10) @(negedge clk);
    check("t2_ar_count_more", ar_addr_log.size() - base, 17);
    check("t2_id_wrap", ar_id_log[base + 16], 4'd0);
    check("t2_outstanding_refill", outstanding, 9'd16);
    check("t2_arvalid_low2", bus.arvalid, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    check("t2_drain_busy", busy, 1'b1);
    check("t2_drain_count", ar_addr_log.size() - base, 17);
    for (int b = 0; b < 16; b++) send_beats(16, 1, 16'h0);
    check("t2_beats", beats_rcvd, 32'd272);
    expect_done("t2");

    // T3: small window wraps after three bursts
    num_w = 5;
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    repeat (8) @(negedge clk);
    check("t3_ar_count", arw_log.size(), 5);
    check("t3_addr0", arw_log[0], 32'h4000_0000);
    check("t3_addr1", arw_log[1], 32'h4000_0100);
    check("t3_addr2", arw_log[2], 32'h4000_0200);
    check("t3_addr3_wrap", arw_log[3], 32'h4000_0000);
    check("t3_addr4", arw_log[4], 32'h4000_0100);
    check("t3_outstanding", outstanding_w, 9'd5);

    // T4: FIFO full stalls the R channel without losing beats
    bus.arready = 1'b1; num_bursts = 1;
    pulse_start();
    repeat (2) @(negedge clk);
    bus.arready = 1'b0;
    send_beats(5, 0, 16'h0);
    check("t4_beats_pre", beats_rcvd, 32'd5);
    bus.fifo_full = 1'b1; bus.rvalid = 1'b1; bus.rdata = 128'd5;
    #1;
    check("t4_rready_low", bus.rready, 1'b0);
    check("t4_wrreq_low", bus.fifo_wrreq, 1'b0);
    repeat (10) @(negedge clk);
    check("t4_beats_stalled", beats_rcvd, 32'd5);
    bus.fifo_full = 1'b0;
    send_beats(11, 1, 16'h0);
    check("t4_beats_post", beats_rcvd, 32'd16);
    check("t4_outstanding", outstanding, 9'd0);
    expect_done("t4");

    // T5: stop while an AR is pending
    bus.arready = 1'b0; num_bursts = 0;
    pulse_start();
    check("t5_arvalid", bus.arvalid, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5_hold_valid%0d", k), bus.arvalid, 1'b1);
      check($sformatf("t5_hold_addr%0d", k), bus.araddr, 32'h4000_0000);
      if (k < 2) @(negedge clk);
    end
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check("t5_arvalid_off", bus.arvalid, 1'b0);
    check("t5_bursts", bursts_issued, 32'd1);
    check("t5_outstanding", outstanding, 9'd1);
    repeat (5) @(negedge clk);
    check("t5_wait_busy", busy, 1'b1);
    check("t5_wait_done", done, 1'b0);
    send_beats(16, 1, 16'h0);
    expect_done("t5");

    // T6: error responses, clear on start, async reset mid-RUN
    bus.arready = 1'b1; num_bursts = 1;
    pulse_start();
    repeat (2) @(negedge clk);
    bus.arready = 1'b0;
    send_beats(16, 1, 16'h0208);
    check("t6_err_beats", err_beats, 32'd2);
    check("t6_err_sticky", err_sticky, 1'b1);
    check("t6_beats", beats_rcvd, 32'd16);
    expect_done("t6");
    check("t6_sticky_idle", err_sticky, 1'b1);
    bus.arready = 1'b1; num_bursts = 3;
    pulse_start();
    check("t6_sticky_clr", err_sticky, 1'b0);
    check("t6_err_clr", err_beats, 32'd0);
    check("t6_beats_clr", beats_rcvd, 32'd0);
    @(negedge clk);
    check("t6_outstanding1", outstanding, 9'd1);
    @(negedge clk);
    check("t6_outstanding2", outstanding, 9'd2);
    check("t6_arvalid_run", bus.arvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_arvalid", bus.arvalid, 1'b0);
    check("t6_rst_outstanding", outstanding, 9'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_bursts", bursts_issued, 32'd0);
    check("t6_rst_araddr", bus.araddr, 32'h4000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
